regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
- REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
- REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width.
- REQ-003 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
- REQ-004 Port reset, input, 1: SHALL be a synchronous, active-low reset.
- REQ-005 Ports reqN_valid (input, 1), reqN_rd (input, ADDR_W), reqN_data (input, DATA_W) and reqN_ready (output, 1), for N=0,1: SHALL form requester N's write-request handshake.
- REQ-006 Port hold, input, 1: SHALL block new grants while high.
- REQ-007 Ports rf_en, rf_writeEn (output, 1), rf_rd (output, ADDR_W) and rf_dataIn (output, DATA_W): SHALL drive the register-file write port.
- REQ-008 Port wr_count, output, 16: SHALL count committed writes.
- REQ-009 Under REGFILE_ARB_FWD_EN only: inputs rs1, rs2 (ADDR_W) and rf_readOut1, rf_readOut2 (DATA_W), plus outputs readOut1, readOut2 (DATA_W), SHALL provide the forwarded read data.

Function
- REQ-010 A transfer SHALL occur on requester N when reqN_valid and reqN_ready are both 1 at a rising clk edge.
- REQ-011 reqN_ready SHALL be combinational and at most one-hot.
- REQ-012 reqN_ready SHALL be 0 whenever hold=0 is false (hold=1) or reset=0.
- REQ-013 Arbitration SHALL be round-robin via a 1-bit priority pointer ptr: if both requesters are valid, requester ptr is granted; if one is valid, it is granted.
- REQ-014 After each transfer, ptr SHALL move to the non-granted requester; with no transfer, ptr SHALL hold.
- REQ-015 FSM states SHALL be IDLE and WRITE.
- REQ-016 Any transfer SHALL enter WRITE next cycle; WRITE with no new transfer SHALL return to IDLE; WRITE with a new transfer SHALL stay in WRITE (back-to-back, one write per cycle).
- REQ-017 Write latency SHALL be exactly 1 cycle: rf_rd and rf_dataIn SHALL be registered from the granted request, and rf_writeEn=1 in the following cycle.
- REQ-018 rf_writeEn SHALL be 1 only in WRITE, and only if the captured rd != 0.
- REQ-019 A request with rd=0 SHALL be accepted but SHALL NOT write and SHALL NOT count.
- REQ-020 wr_count SHALL increment by 1 per cycle with rf_writeEn=1 and SHALL wrap 0xFFFF -> 0x0000.
- REQ-021 rf_en SHALL be 1 whenever reset=1.
- REQ-022 hold rising SHALL NOT cancel a write already captured; that write completes next cycle.

Reset
- REQ-023 While reset=0 at a clk edge, the block SHALL set state=IDLE, ptr=0, rf_writeEn=0, rf_rd=0, rf_dataIn=0, wr_count=0 and rf_en=0.
- REQ-024 Reset asserted mid-WRITE SHALL suppress that write: rf_writeEn=0 in the cycle after the reset edge.
- REQ-025 The first grant after reset release SHALL be eligible on the first edge with reset=1.

Configuration
- REQ-026 With REGFILE_ARB_FWD_EN defined: readOutK SHALL equal rf_dataIn when rf_writeEn=1 and rf_rd==rsK; otherwise readOutK SHALL equal rf_readOutK. This path is combinational, K=1,2.
- REQ-027 Without REGFILE_ARB_FWD_EN: the forwarding ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
- REQ-028 Shared package regfile_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_WRITE), REG_ADDR_W=5, REG_DATA_W=32 and ZERO_REG=0.
- REQ-029 Round-robin selection SHALL be one sub-module, rr_arb2 (inputs: two valids, ptr; outputs: one-hot grant).
- REQ-030 All other logic SHALL remain in regfile_wb_arbiter.

Verification
- REQ-031 Reset: hold reset=0 for 3 cycles, then release -> all outputs 0, ready=0 during reset, rf_en=1 after release.
- REQ-032 Contention: req0 (rd=3, data=0xA5A5A5A5) and req1 (rd=4, data=0x12345678) both valid continuously after reset -> grants alternate 0,1,0,1; writes appear 1 cycle after each grant; wr_count=4 after 4 grants.
- REQ-033 x0 write: req0 rd=0, data=0xFFFFFFFF -> ready=1, rf_writeEn stays 0, wr_count unchanged.
- REQ-034 Hold: hold=1 with both requesters valid -> ready=0 for both for 5 cycles, and a write captured in the cycle before hold still commits.
- REQ-035 Wrap and mid-write reset: preload wr_count to 0xFFFF by issuing 65535 writes, then one more write -> 0x0000; reset=0 in a WRITE cycle -> no rf_writeEn pulse.
- REQ-036 Forwarding (with REGFILE_ARB_FWD_EN): rf_writeEn=1, rf_rd=7, rf_dataIn=0xDEADBEEF, rs1=7, rs2=8 -> readOut1=0xDEADBEEF and readOut2=rf_readOut2.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds the arbiter FSM encoding and default register-file geometry.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: grants requester ptr on contention, else the lone valid one.
// Purely combinational, zero latency; a grant is only ever given to a valid requester.
// No backpressure of its own; the caller gates the grant with its stall conditions.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant[0] = valid0 & (~valid1 | ~ptr);
  assign grant[1] = valid1 & (~valid0 | ptr);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two write-back requesters onto one register-file write port; writes land 1 cycle after grant.
// hold or reset drops both readies; optional read forwarding under REGFILE_ARB_FWD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              hold,
  output logic              rf_en,
  output logic              rf_writeEn,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_dataIn,
  output logic [15:0]       wr_count
`ifdef REGFILE_ARB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] rf_readOut1,
  input  logic [DATA_W-1:0] rf_readOut2,
  output logic [DATA_W-1:0] readOut1,
  output logic [DATA_W-1:0] readOut2
`endif
);

  arb_state_t        state;
  logic              ptr;
  logic [1:0]        grant;
  logic              open;
  logic              xfer0;
  logic              xfer1;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  rr_arb2 u_rr (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (ptr),
    .grant  (grant)
  );

  assign open       = reset & ~hold;
  assign req0_ready = grant[0] & open;
  assign req1_ready = grant[1] & open;
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;
  assign sel_rd     = xfer1 ? req1_rd   : req0_rd;
  assign sel_data   = xfer1 ? req1_data : req0_data;

  assign rf_en = reset;

  // A captured request always lands next cycle, even if hold rises meanwhile;
  // x0 targets are accepted but never raise rf_writeEn.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      ptr        <= 1'b0;
      rf_writeEn <= 1'b0;
      rf_rd      <= '0;
      rf_dataIn  <= '0;
      wr_count   <= '0;
    end else begin
      if (rf_writeEn)
        wr_count <= wr_count + 16'd1;
      if (xfer0 | xfer1) begin
        state      <= ARB_WRITE;
        ptr        <= ~xfer1;
        rf_rd      <= sel_rd;
        rf_dataIn  <= sel_data;
        rf_writeEn <= (sel_rd != ADDR_W'(ZERO_REG));
      end else begin
        if (state == ARB_WRITE)
          state <= ARB_IDLE;
        rf_writeEn <= 1'b0;
      end
    end
  end

`ifdef REGFILE_ARB_FWD_EN
  assign readOut1 = (rf_writeEn && rf_rd == rs1) ? rf_dataIn : rf_readOut1;
  assign readOut2 = (rf_writeEn && rf_rd == rs2) ? rf_dataIn : rf_readOut2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a transaction-level reference model.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_rd, req1_rd;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          hold;
  logic          rf_en, rf_writeEn;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_dataIn;
  logic [15:0]   wr_count;
`ifdef REGFILE_ARB_FWD_EN
  logic [AW-1:0] rs1, rs2;
  logic [DW-1:0] rf_readOut1, rf_readOut2, readOut1, readOut2;
`endif

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .hold       (hold),
    .rf_en      (rf_en),
    .rf_writeEn (rf_writeEn),
    .rf_rd      (rf_rd),
    .rf_dataIn  (rf_dataIn),
    .wr_count   (wr_count)
`ifdef REGFILE_ARB_FWD_EN
    ,
    .rs1         (rs1),
    .rs2         (rs2),
    .rf_readOut1 (rf_readOut1),
    .rf_readOut2 (rf_readOut2),
    .readOut1    (readOut1),
    .readOut2    (readOut2)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the write that is pending for next cycle and the running write count.
  bit          m_ptr   = 1'b0;
  bit          m_we    = 1'b0;
  bit [AW-1:0] m_rd    = '0;
  bit [DW-1:0] m_data  = '0;
  int          m_count = 0;

  logic obs_rdy0, obs_rdy1;
  int   obs_grant;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model at the edge, check registered outputs.
  task automatic cycle();
    bit g0, g1;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset && !hold) begin
      if (req0_valid && req1_valid) begin
        if (m_ptr) g1 = 1'b1; else g0 = 1'b1;
      end else if (req0_valid) g0 = 1'b1;
      else if (req1_valid)     g1 = 1'b1;
    end
    check("ready0", req0_ready, g0);
    check("ready1", req1_ready, g1);
    check("rf_en", rf_en, reset);
`ifdef REGFILE_ARB_FWD_EN
    check("readOut1", readOut1, (m_we && m_rd == rs1) ? m_data : rf_readOut1);
    check("readOut2", readOut2, (m_we && m_rd == rs2) ? m_data : rf_readOut2);
`endif
    obs_rdy0  = req0_ready;
    obs_rdy1  = req1_ready;
    obs_grant = req1_ready ? 1 : 0;
    @(posedge clk);
    if (!reset) begin
      m_ptr = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0; m_count = 0;
    end else begin
      if (m_we) m_count = (m_count + 1) % 65536;
      if (g0 || g1) begin
        m_ptr  = g0;
        m_rd   = g0 ? req0_rd : req1_rd;
        m_data = g0 ? req0_data : req1_data;
        m_we   = (m_rd != 0);
      end else begin
        m_we = 1'b0;
      end
    end
    @(negedge clk);
    check("rf_writeEn", rf_writeEn, m_we);
    check("rf_rd", rf_rd, m_rd);
    check("rf_dataIn", rf_dataIn, m_data);
    check("wr_count", wr_count, m_count[15:0]);
  endtask

  initial begin
    int c0;
    reset = 1'b0; hold = 1'b0;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
`ifdef REGFILE_ARB_FWD_EN
    rs1 = '0; rs2 = '0; rf_readOut1 = '0; rf_readOut2 = '0;
`endif
    @(negedge clk);

    // Reset held for 3 cycles with requests pending: no ready, outputs cleared.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) begin
      cycle();
      check("rst_rdy", {obs_rdy1, obs_rdy0}, 2'b00);
    end
    check("rst_cnt", wr_count, 16'h0);
    check("rst_we", rf_writeEn, 1'b0);

    // Contention: both valid from the first edge after release, grants alternate 0,1,0,1.
    reset = 1'b1;
    req0_rd = 5'd3; req0_data = 32'hA5A5A5A5;
    req1_rd = 5'd4; req1_data = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_order", obs_grant, i % 2);
      check("rr_wr_rd", rf_rd, (i % 2) ? 5'd4 : 5'd3);
      check("rr_wr_en", rf_writeEn, 1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle(); cycle();
    check("rr_cnt4", wr_count, 16'd4);

    // Write to x0: accepted, no write pulse, count unchanged.
    c0 = wr_count;
    req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hFFFFFFFF;
    cycle();
    check("x0_rdy", obs_rdy0, 1'b1);
    check("x0_we", rf_writeEn, 1'b0);
    req0_valid = 1'b0;
    cycle(); cycle();
    check("x0_cnt", wr_count, c0[15:0]);

    // Hold: a write captured just before hold still commits; no grants for 5 cycles.
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h0BADF00D;
    req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'h600DCAFE;
    cycle();
    c0 = wr_count;
    hold = 1'b1;
    check("hold_pend", rf_writeEn, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_rdy", {obs_rdy1, obs_rdy0}, 2'b00);
      if (i == 0) check("hold_commit", wr_count, c0[15:0] + 16'd1);
    end
    hold = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();

    // Wrap: 65535 writes from zero, then one more.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1;
    repeat (65535) cycle();
    req0_valid = 1'b0;
    cycle(); cycle();
    check("cnt_ffff", wr_count, 16'hFFFF);
    req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    cycle(); cycle();
    check("cnt_wrap", wr_count, 16'h0000);

    // Reset arriving during a WRITE cycle suppresses that write.
    req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'hCAFEBABE;
    cycle();
    req0_valid = 1'b0;
    check("mw_pend", rf_writeEn, 1'b1);
    reset = 1'b0;
    cycle();
    check("mw_supp", rf_writeEn, 1'b0);
    reset = 1'b1;

`ifdef REGFILE_ARB_FWD_EN
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'hDEADBEEF;
    cycle();
    req0_valid = 1'b0;
    rs1 = 5'd7; rs2 = 5'd8; rf_readOut1 = 32'h11111111; rf_readOut2 = 32'h22222222;
    #1;
    check("fwd_hit", readOut1, 32'hDEADBEEF);
    check("fwd_miss", readOut2, 32'h22222222);
    cycle();
`endif

    // Randomised traffic against the model.
    repeat (3000) begin
      reset      = ($urandom_range(0, 31) != 0);
      hold       = ($urandom_range(0, 3) == 0);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      req1_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      req0_data  = $urandom;
      req1_data  = $urandom;
`ifdef REGFILE_ARB_FWD_EN
      rs1 = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      rs2 = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      rf_readOut1 = $urandom;
      rf_readOut2 = $urandom;
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
